view_input_conditioner: RTL and testbench
=========================================

Name: view_input_conditioner

Overview:
- Upstream feeder of the view controller: converts six raw board buttons into the clean, stable pan/zoom level signals the controller samples once per poll tick.
- Per-button work: 2-flop synchronisation, counter-based debounce, opposite-direction cancellation.
- Extra output: a one-shot recenter request when both zoom buttons are held long enough.
- All outputs are registered. They change only after a debounced transition, so they stay stable across the controller's multi-cycle FP arithmetic.

Parameters:
- DEBOUNCE_CYCLES, 500000, consecutive post-sync cycles an input must disagree with its debounced state before the state flips (10 ms @ 50 MHz); minimum 2.
- RECENTER_CYCLES, 100000000, cycles both debounced zoom inputs must be held before recenter_req fires (2 s @ 50 MHz); minimum 2.
- INPUT_ACTIVE_LOW, 1, 1: btn_raw bit = 0 means pressed; 0: bit = 1 means pressed.

Ports:
- clock  input  1  system clock
- reset_n  input  1  reset
- btn_raw  input  6  asynchronous buttons; [0] up, [1] down, [2] left, [3] right, [4] zoom_in, [5] zoom_out
- pan_up  output  1  debounced, conflict-resolved level
- pan_down  output  1  same
- pan_left  output  1  same
- pan_right  output  1  same
- zoom_in  output  1  same
- zoom_out  output  1  same
- recenter_req  output  1  single-cycle pulse
- any_active  output  1  OR of the six pan/zoom outputs

Interface decisions:
- Reset is reset_n, asynchronous, active-low; clock is clock.
- All state is on rising clock edges.

Behaviour:
- Reset values:
  - All outputs 0.
  - Debounced states 0 (released).
  - All counters 0.
  - Sync flops 0 after polarity normalisation, i.e. "released".
- Normalisation: pressed = btn_raw XOR {6{INPUT_ACTIVE_LOW}}. This is applied before the two sync flops (s1, s2). s2 is the only signal used downstream.
- Debounce, per bit i, with debounced state deb[i] and counter cnt[i] (width clog2(DEBOUNCE_CYCLES)):
  - If s2[i] == deb[i]: cnt[i] <= 0.
  - Else if cnt[i] == DEBOUNCE_CYCLES-1: deb[i] <= s2[i] and cnt[i] <= 0.
  - Else: cnt[i] <= cnt[i]+1.
  - A disagreement lasting fewer than DEBOUNCE_CYCLES consecutive cycles never changes deb. Any agreeing cycle restarts the count.
- Conflict resolution (registered, one cycle after deb):
  - pan_up = deb[0] & ~deb[1]; pan_down = deb[1] & ~deb[0].
  - pan_left = deb[2] & ~deb[3]; pan_right = deb[3] & ~deb[2].
  - zoom_in = deb[4] & ~deb[5]; zoom_out = deb[5] & ~deb[4].
  - An opposite pair held together yields 0 on both outputs.
  - Orthogonal pan plus zoom combinations pass through unchanged.
- any_active: registered OR of the six resolved outputs, computed from the same deb values, so it is time-aligned with them.
- Latency: a clean raw edge appears on its output exactly DEBOUNCE_CYCLES+3 rising edges after it is first sampled (2 sync + DEBOUNCE_CYCLES + 1 output register). Press and release have the same latency.
- Recenter, using counter rc (width clog2(RECENTER_CYCLES)) and flag fired:
  - If deb[4] & deb[5] are not both set: rc <= 0, fired <= 0.
  - Else if !fired and rc == RECENTER_CYCLES-1: recenter_req <= 1 for exactly one cycle, fired <= 1.
  - Else if !fired: rc <= rc+1.
  - Continued holding after firing produces no further pulses. Releasing either zoom button re-arms the counter.
  - recenter_req is 0 in every cycle it is not explicitly pulsed.
- Reset mid-operation: everything returns to reset values immediately (asynchronously). A button still held at reset release is treated as a new press and appears after DEBOUNCE_CYCLES+3 edges.
- Counters never wrap: each is cleared on reaching its terminal value or on agreement/release.

Test Plan (DEBOUNCE_CYCLES=4, RECENTER_CYCLES=16, INPUT_ACTIVE_LOW=1):
1. Reset, btn_raw=6'b111111 -> all outputs 0. Drive btn_raw[3]=0 held -> pan_right=1 and any_active=1 exactly 7 edges later; release -> pan_right=0 exactly 7 edges after release.
2. Glitch btn_raw[0]=0 for 3 cycles, then 1 -> pan_up stays 0 throughout. Repeat with a 4-cycle pulse -> pan_up rises, then falls 4+3 edges after the release.
3. Hold btn_raw[0] and btn_raw[1] both 0 -> pan_up=pan_down=0 and any_active=0. Add btn_raw[2]=0 -> pan_left=1 while up/down stay 0.
4. Hold btn_raw[4] and btn_raw[5] both 0 -> zoom_in=zoom_out=0, and recenter_req pulses high exactly one cycle, 16 cycles after both deb bits are set. Keep holding 100 more cycles -> no further pulse. Release btn_raw[5] and re-press -> a second single pulse.
5. Hold btn_raw[4]=0, assert reset_n=0 for 2 cycles mid-hold, deassert -> zoom_in=0 immediately, then 1 again 7 edges after reset release.
6. Chatter btn_raw[1] toggling every 2 cycles for 40 cycles -> pan_down never changes; each counter clears on agreement.

Source files
------------

// File: rtl/view_input_conditioner.sv
// Conditions six raw board buttons into clean pan/zoom levels for the view controller:
// polarity normalisation, 2-flop sync, counter debounce, opposite-pair cancellation, recenter pulse.
module view_input_conditioner #(
  parameter int DEBOUNCE_CYCLES  = 500000,
  parameter int RECENTER_CYCLES  = 100000000,
  parameter int INPUT_ACTIVE_LOW = 1
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic [5:0] btn_raw,
  output logic       pan_up,
  output logic       pan_down,
  output logic       pan_left,
  output logic       pan_right,
  output logic       zoom_in,
  output logic       zoom_out,
  output logic       recenter_req,
  output logic       any_active
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES);
  localparam int RW = $clog2(RECENTER_CYCLES);
  localparam logic [DW-1:0] DEB_LAST = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [RW-1:0] RC_LAST  = RW'(RECENTER_CYCLES - 1);
  localparam logic [5:0]    POL      = (INPUT_ACTIVE_LOW != 0) ? 6'h3f : 6'h00;

  logic [5:0] s1;
  logic [5:0] s2;
  logic [5:0] deb;
  logic [5:0] res;
  logic [5:0] lvl;

  // Normalise to "1 = pressed" ahead of the synchroniser so reset means released.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= btn_raw ^ POL;
      s2 <= s1;
    end
  end

  for (genvar i = 0; i < 6; i++) begin : g_deb
    logic          deb_q;
    logic [DW-1:0] cnt_q;

    always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
        deb_q <= 1'b0;
        cnt_q <= '0;
      end else if (s2[i] == deb_q) begin
        cnt_q <= '0;
      end else if (cnt_q == DEB_LAST) begin
        deb_q <= s2[i];
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end

    assign deb[i] = deb_q;
  end

  // Opposite pairs cancel; each output only sees its own axis.
  always_comb begin
    res    = '0;
    res[0] = deb[0] & ~deb[1];
    res[1] = deb[1] & ~deb[0];
    res[2] = deb[2] & ~deb[3];
    res[3] = deb[3] & ~deb[2];
    res[4] = deb[4] & ~deb[5];
    res[5] = deb[5] & ~deb[4];
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      lvl        <= '0;
      any_active <= 1'b0;
    end else begin
      lvl        <= res;
      any_active <= |res;
    end
  end

  assign pan_up    = lvl[0];
  assign pan_down  = lvl[1];
  assign pan_left  = lvl[2];
  assign pan_right = lvl[3];
  assign zoom_in   = lvl[4];
  assign zoom_out  = lvl[5];

  logic [RW-1:0] rc;
  logic          fired;

  // One pulse per continuous both-zoom hold; releasing either button re-arms.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rc           <= '0;
      fired        <= 1'b0;
      recenter_req <= 1'b0;
    end else begin
      recenter_req <= 1'b0;
      if (!(deb[4] & deb[5])) begin
        rc    <= '0;
        fired <= 1'b0;
      end else if (!fired) begin
        if (rc == RC_LAST) begin
          recenter_req <= 1'b1;
          fired        <= 1'b1;
          rc           <= '0;
        end else begin
          rc <= rc + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_view_input_conditioner.sv
// Directed bench for view_input_conditioner with short debounce/recenter windows.
module tb_view_input_conditioner;

  logic       clock;
  logic       reset_n;
  logic [5:0] btn_raw;
  logic       pan_up, pan_down, pan_left, pan_right, zoom_in, zoom_out;
  logic       recenter_req, any_active;

  int errors = 0;
  int checks = 0;

  view_input_conditioner #(
    .DEBOUNCE_CYCLES (4),
    .RECENTER_CYCLES (16),
    .INPUT_ACTIVE_LOW(1)
  ) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .btn_raw     (btn_raw),
    .pan_up      (pan_up),
    .pan_down    (pan_down),
    .pan_left    (pan_left),
    .pan_right   (pan_right),
    .zoom_in     (zoom_in),
    .zoom_out    (zoom_out),
    .recenter_req(recenter_req),
    .any_active  (any_active)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // {any_active, recenter_req, zoom_out, zoom_in, pan_right, pan_left, pan_down, pan_up}
  function automatic logic [7:0] outs();
    return {any_active, recenter_req, zoom_out, zoom_in, pan_right, pan_left, pan_down, pan_up};
  endfunction

  localparam logic [7:0] O_NONE  = 8'b0000_0000;
  localparam logic [7:0] O_UP    = 8'b1000_0001;
  localparam logic [7:0] O_LEFT  = 8'b1000_0100;
  localparam logic [7:0] O_RIGHT = 8'b1000_1000;
  localparam logic [7:0] O_ZIN   = 8'b1001_0000;
  localparam logic [7:0] O_RC    = 8'b0100_0000;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  initial begin
    reset_n = 1'b0;
    btn_raw = 6'b111111;
    tick(3);
    chk("reset_outs", outs(), O_NONE);
    reset_n = 1'b1;
    tick(2);
    chk("idle_outs", outs(), O_NONE);

    // 1: right press/release latency
    btn_raw[3] = 1'b0;
    tick(6);
    chk("right_press_e6", outs(), O_NONE);
    tick(1);
    chk("right_press_e7", outs(), O_RIGHT);
    btn_raw[3] = 1'b1;
    tick(6);
    chk("right_rel_e6", outs(), O_RIGHT);
    tick(1);
    chk("right_rel_e7", outs(), O_NONE);
    tick(4);

    // 2: 3-cycle glitch rejected, 4-cycle pulse accepted
    btn_raw[0] = 1'b0;
    tick(3);
    btn_raw[0] = 1'b1;
    for (int k = 0; k < 12; k++) begin
      chk("glitch3", outs(), O_NONE);
      tick(1);
    end
    btn_raw[0] = 1'b0;
    tick(4);
    btn_raw[0] = 1'b1;
    tick(2);
    chk("pulse4_e6", outs(), O_NONE);
    tick(1);
    chk("pulse4_e7", outs(), O_UP);
    tick(3);
    chk("pulse4_rel_e6", outs(), O_UP);
    tick(1);
    chk("pulse4_rel_e7", outs(), O_NONE);
    tick(4);

    // 3: opposite pan cancels, orthogonal passes
    btn_raw[1:0] = 2'b00;
    tick(10);
    chk("updown_cancel", outs(), O_NONE);
    btn_raw[2] = 1'b0;
    tick(6);
    chk("left_e6", outs(), O_NONE);
    tick(1);
    chk("left_e7", outs(), O_LEFT);
    btn_raw = 6'b111111;
    tick(10);
    chk("pan_released", outs(), O_NONE);

    // 4: both zoom -> cancellation plus one recenter pulse
    btn_raw[5:4] = 2'b00;
    tick(7);
    chk("zoom_cancel", outs(), O_NONE);
    for (int k = 8; k < 22; k++) begin
      tick(1);
      chk("rc_wait", outs(), O_NONE);
    end
    tick(1);
    chk("rc_pulse", outs(), O_RC);
    tick(1);
    chk("rc_pulse_end", outs(), O_NONE);
    for (int k = 0; k < 100; k++) begin
      tick(1);
      chk("rc_hold", outs(), O_NONE);
    end
    btn_raw[5] = 1'b1;
    tick(10);
    chk("zoom_out_rel", outs(), O_ZIN);
    btn_raw[5] = 1'b0;
    tick(7);
    chk("rearm_cancel", outs(), O_NONE);
    for (int k = 8; k < 22; k++) begin
      tick(1);
      chk("rc2_wait", outs(), O_NONE);
    end
    tick(1);
    chk("rc2_pulse", outs(), O_RC);
    tick(1);
    chk("rc2_pulse_end", outs(), O_NONE);
    btn_raw = 6'b111111;
    tick(10);
    chk("zoom_released", outs(), O_NONE);

    // 5: async reset mid-hold
    btn_raw[4] = 1'b0;
    tick(10);
    chk("zin_held", outs(), O_ZIN);
    reset_n = 1'b0;
    #1;
    chk("zin_async_rst", outs(), O_NONE);
    tick(2);
    reset_n = 1'b1;
    tick(6);
    chk("zin_after_rst_e6", outs(), O_NONE);
    tick(1);
    chk("zin_after_rst_e7", outs(), O_ZIN);
    btn_raw = 6'b111111;
    tick(10);
    chk("zin_released", outs(), O_NONE);

    // 6: chatter on down never gets through
    for (int k = 0; k < 20; k++) begin
      btn_raw[1] = ~btn_raw[1];
      tick(1);
      chk("chatter", outs(), O_NONE);
      tick(1);
      chk("chatter", outs(), O_NONE);
    end
    btn_raw = 6'b111111;
    tick(10);
    chk("chatter_end", outs(), O_NONE);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
